// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver.
// Recovers start / DATA_WIDTH data bits (LSB first) / optional parity / stop
// and presents the word with a one-cycle data_valid strobe, or reports
// parity and stop-bit errors with one-cycle strobes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle, waiting for a 1 -> 0 transition on rx_in
// START  | inside start bit; a sampled 1 is a glitch and aborts
// DATA   | inside data bit bit_cnt, sampled bit stored LSB first
// PARITY | inside parity bit, mismatch against expected parity recorded
// STOP   | inside stop bit; frame resolved at the sample point
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q,    state_d;
    logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [PRESC_W-1:0]    presc_q,    presc_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_typ_q,  par_typ_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  s0_q,       s0_d;
    logic                  s1_q,       s1_d;
    logic                  par_bad_q,  par_bad_d;
    logic                  rx_prev_q,  rx_prev_d;
    logic [DATA_WIDTH-1:0] p_data_q,   p_data_d;
    logic                  dv_q,       dv_d;
    logic                  pe_q,       pe_d;
    logic                  se_q,       se_d;

    logic [PRESC_W-1:0]    half;
    logic                  samp_a;
    logic                  samp_b;
    logic                  samp_pt;
    logic                  bit_end;
    logic                  maj;
    logic                  exp_par;

    // Sample-point decode against the prescale captured at frame start.
    always_comb begin
        half    = presc_q >> 1;
        samp_a  = (edge_cnt_q == half - PRESC_W'(2));
        samp_b  = (edge_cnt_q == half - PRESC_W'(1));
        samp_pt = (edge_cnt_q == half);
        bit_end = (edge_cnt_q == presc_q - PRESC_W'(1));
        // Third vote is the live line value at the sample point itself.
        maj     = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
        exp_par = par_typ_q ? ~^shift_q : ^shift_q;
    end

    // Next-state logic for the frame FSM, counters and strobes.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        shift_d    = shift_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        par_bad_d  = par_bad_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        rx_prev_d  = rx_in;

        if (state_q != S_IDLE) begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESC_W'(1);
            if (samp_a) s0_d = rx_in;
            if (samp_b) s1_d = rx_in;
        end

        case (state_q)
            S_IDLE: begin
                // Needs a real 1 -> 0 edge so a held-low line does not re-arm.
                if (rx_prev_q && !rx_in) begin
                    state_d    = S_START;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    presc_d    = prescale;
                    par_en_d   = par_en;
                    par_typ_d  = par_typ;
                    par_bad_d  = 1'b0;
                end
            end
            S_START: begin
                if (samp_pt && maj) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (samp_pt) shift_d[bit_cnt_q] = maj;
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (samp_pt) par_bad_d = (maj != exp_par);
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Leaving at mid-stop-bit leaves margin for back-to-back frames.
                if (samp_pt) begin
                    se_d = !maj;
                    pe_d = par_bad_q;
                    if (maj && !par_bad_q) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            shift_q    <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            par_bad_q  <= 1'b0;
            rx_prev_q  <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            shift_q    <= shift_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            par_bad_q  <= par_bad_d;
            rx_prev_q  <= rx_prev_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. The driver pushes the expected
// outcome of every frame (strobes, word, arrival cycle) when it starts the
// frame; an independent monitor pops and compares whenever a strobe appears.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] pdata;
        longint     at;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_pdata = 8'h00;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe cycle must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (data_valid || par_err || stp_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: dv=%0b pe=%0b se=%0b at cycle %0d, none expected",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data_valid", longint'(data_valid), longint'(e.dv));
                check("par_err",    longint'(par_err),    longint'(e.pe));
                check("stp_err",    longint'(stp_err),    longint'(e.se));
                check("p_data",     longint'(p_data),     longint'(e.pdata));
                check("strobe_cycle", cyc, e.at);
            end
        end
    end

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at a negedge; optionally scrambles the
    // configuration inputs after the start edge to prove they are latched.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe,
                              input bit pt, input bit pbit, input bit sbit,
                              input bit scramble);
        exp_t e;
        bit   par_ok;
        int   nbits;
        prescale = 6'(p);
        par_en   = pe;
        par_typ  = pt;
        par_ok   = !pe || ((($countones(d) + int'(pbit)) % 2) == (pt ? 1 : 0));
        e.dv     = par_ok && sbit;
        e.pe     = !par_ok;
        e.se     = !sbit;
        if (e.dv) model_pdata = d;
        e.pdata  = model_pdata;
        nbits    = 8 + int'(pe) + 1;
        e.at     = cyc + 1 + longint'(nbits * p + p / 2 + 1);
        sb.push_back(e);
        rx_in = 1'b0;
        @(negedge clk);
        if (scramble) begin
            prescale = 6'(8 << $urandom_range(0, 2));
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
        end
        repeat (p - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (p) @(negedge clk);
        end
        if (pe) begin
            rx_in = pbit;
            repeat (p) @(negedge clk);
        end
        rx_in = sbit;
        repeat (p) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, outstanding=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         p;
        bit         pe, pt, pbit, sbit;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_p_data",     longint'(p_data),     0);
        check("reset_data_valid", longint'(data_valid), 0);
        check("reset_par_err",    longint'(par_err),    0);
        check("reset_stp_err",    longint'(stp_err),    0);
        idle(4);

        // Odd parity, correct parity bit 0.
        send_frame(8'h9B, 8, 1, 1, 0, 1, 0);
        idle(3);
        // Even parity, parity bit wrong: par_err, p_data keeps 0x9B.
        send_frame(8'h6B, 8, 1, 0, 0, 1, 0);
        idle(3);
        // Stop bit low: stp_err, then a good frame.
        send_frame(8'hAC, 16, 0, 0, 0, 0, 0);
        idle(5);
        send_frame(8'h35, 16, 0, 0, 0, 1, 0);
        idle(3);
        // Two-clock glitch, then a good frame.
        prescale = 6'd8;
        par_en   = 1'b0;
        rx_in    = 1'b0;
        repeat (2) @(negedge clk);
        idle(12);
        send_frame(8'h5A, 8, 0, 0, 0, 1, 0);
        idle(3);
        // Back-to-back frames with no idle gap.
        send_frame(8'h01, 32, 0, 0, 0, 1, 0);
        send_frame(8'hFE, 32, 0, 0, 0, 1, 0);
        idle(3);

        // Reset during data bit 3 of an aborted frame.
        prescale = 6'd8;
        par_en   = 1'b0;
        d        = 8'hA5;
        rx_in    = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = d[i];
            repeat (8) @(negedge clk);
        end
        rx_in = d[3];
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check("rst_p_data",     longint'(p_data),     0);
        check("rst_data_valid", longint'(data_valid), 0);
        check("rst_par_err",    longint'(par_err),    0);
        check("rst_stp_err",    longint'(stp_err),    0);
        rst = 1'b0;
        model_pdata = 8'h00;
        idle(10);
        send_frame(8'hC3, 8, 0, 0, 0, 1, 0);
        idle(3);

        // Randomized frames with occasional parity/stop errors.
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            p    = 8 << $urandom_range(0, 2);
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            pbit = pt ? ~^d : ^d;
            if ($urandom_range(0, 4) == 0) pbit = ~pbit;
            sbit = ($urandom_range(0, 5) != 0);
            send_frame(d, p, pe, pt, pbit, sbit, 1'($urandom));
            if (!sbit) idle($urandom_range(1, 4));
            else idle($urandom_range(0, 3));
        end

        idle(4);
        for (int w = 0; w < 1000 && sb.size() != 0; w++) @(negedge clk);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe: no strobe observed for frame, expected dv=%0b pe=%0b se=%0b at cycle %0d",
                     e.dv, e.pe, e.se, e.at);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
